// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - TinyMIPS controller states, ISA constants and state decode helpers
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [3:0] irwrite;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] aluop;
    } ctl_t;

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        case (s)
            FETCH1:  next_state = FETCH2;
            FETCH2:  next_state = FETCH3;
            FETCH3:  next_state = FETCH4;
            FETCH4:  next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_J:         next_state = JEX;
                    OP_ADDI:      next_state = ADDIEX;
                    default:      next_state = FETCH1;
                endcase
            end
            MEMADR:  next_state = (op == OP_LB) ? LBRD : SBWR;
            LBRD:    next_state = LBWR;
            RTYPEEX: next_state = RTYPEWR;
            ADDIEX:  next_state = ADDIWR;
            default: next_state = FETCH1;
        endcase
    endfunction

    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                c.pcwrite = 1'b1;
                c.irwrite = 4'b0001 << s[1:0];
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            LBRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            LBWR: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            SBWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            RTYPEWR: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca     = 1'b1;
                c.aluop       = ALUOP_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
            end
            JEX: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
            end
            ADDIWR:  c.regwrite = 1'b1;
            default: c = '0;
        endcase
        state_ctl = c;
    endfunction

endpackage

// File: rtl/mips_if.sv
// rtl/mips_if.sv - controller <-> datapath signal bundle
interface mips_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [3:0] irwrite;
    logic [1:0] pcsource;
    logic       pcen;
    logic [2:0] alucont;

    modport master (
        input  op, funct, zero,
        output memread, memwrite, alusrca, alusrcb, iord, memtoreg,
               regdst, regwrite, irwrite, pcsource, pcen, alucont
    );

    modport slave (
        output op, funct, zero,
        input  memread, memwrite, alusrca, alusrcb, iord, memtoreg,
               regdst, regwrite, irwrite, pcsource, pcen, alucont
    );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps FSM aluop and R-type funct to the ALU control word
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);

    always_comb begin
        alucont = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucont = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucont = ALU_ADD;
                    FN_SUB:  alucont = ALU_SUB;
                    FN_AND:  alucont = ALU_AND;
                    FN_OR:   alucont = ALU_OR;
                    FN_SLT:  alucont = ALU_SLT;
                    default: alucont = ALU_ADD;
                endcase
            end
            default: alucont = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - multicycle Moore control FSM for the 8-bit TinyMIPS datapath
module mips_controller
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    mips_if.master bus
);

    state_t state;
    ctl_t   ctl;

    // Control word is registered from the next state, so it always equals state_ctl(state).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH1;
            ctl   <= state_ctl(FETCH1);
        end else begin
            state <= next_state(state, bus.op);
            ctl   <= state_ctl(next_state(state, bus.op));
        end
    end

    assign bus.memread  = ctl.memread;
    assign bus.memwrite = ctl.memwrite;
    assign bus.alusrca  = ctl.alusrca;
    assign bus.alusrcb  = ctl.alusrcb;
    assign bus.iord     = ctl.iord;
    assign bus.memtoreg = ctl.memtoreg;
    assign bus.regdst   = ctl.regdst;
    assign bus.regwrite = ctl.regwrite;
    assign bus.irwrite  = ctl.irwrite;
    assign bus.pcsource = ctl.pcsource;

    // Branch resolution must see zero in the same cycle, so pcen stays combinational.
    assign bus.pcen = ctl.pcwrite | (ctl.pcwritecond & bus.zero);

    alu_decoder u_alu_decoder (
        .aluop   (ctl.aluop),
        .funct   (bus.funct),
        .alucont (bus.alucont)
    );

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control unit for the 8-bit TinyMIPS datapath: a Moore FSM that fetches each 32-bit instruction one byte per cycle, decodes it, and sequences datapath enables and mux selects. It sits directly upstream of the ALU. It produces the 3-bit ALU control word through a small decoder driven by the FSM's aluop and the instruction funct field. The ALU's zero result feeds back in for branch resolution.

## Interface
- No parameters; widths are fixed by the ISA.
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- op  in  6  instruction opcode, instr[31:26]
- funct  in  6  R-type function field, instr[5:0]
- zero  in  1  ALU result == 0
- memread, memwrite  out  1 each  memory strobes
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = reg B, 01 = const 1, 10 = imm, 11 = imm (branch offset)
- iord  out  1  memory address: 0 = PC, 1 = ALU out
- memtoreg  out  1  writeback from memory data
- regdst  out  1  write reg: 0 = rt, 1 = rd
- regwrite  out  1  register file write
- irwrite  out  4  one-hot instruction-byte load enable
- pcsource  out  2  next PC: 00 = ALU, 01 = ALU out, 10 = jump target
- pcen  out  1  PC load
- alucont  out  3  ALU control word

## Operation
- State register: 4 bits. All outputs except pcen and alucont are pure functions of state. Any signal not listed for a state is 0.
  - FETCH1..FETCH4: memread, alusrcb=01, pcwrite, irwrite=0001/0010/0100/1000 respectively.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca, alusrcb=10.
  - LBRD: memread, iord.
  - LBWR: regwrite, memtoreg.
  - SBWR: memwrite, iord.
  - RTYPEEX: alusrca, aluop=10.
  - RTYPEWR: regdst, regwrite.
  - BEQEX: alusrca, aluop=01, pcwritecond, pcsource=01.
  - JEX: pcwrite, pcsource=10.
  - ADDIEX: alusrca, alusrcb=10.
  - ADDIWR: regwrite.
- pcen = pcwrite | (pcwritecond & zero). This is combinational from state and zero.
- Transitions:
  - FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
  - From DECODE, by op:
    - 100000 (lb) or 101000 (sb) → MEMADR.
    - 000000 → RTYPEEX.
    - 000100 (beq) → BEQEX.
    - 000010 (j) → JEX.
    - 001000 (addi) → ADDIEX.
    - Any other opcode → FETCH1 (no-op; no write strobes asserted).
  - From MEMADR: lb → LBRD, otherwise → SBWR.
  - LBRD→LBWR; RTYPEEX→RTYPEWR; ADDIEX→ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR → FETCH1.
  - Unused state encodings → FETCH1.
- alucont decode:
  - aluop=00 → 010 (add).
  - aluop=01 → 110 (sub).
  - aluop=10, by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct → 010.
  - aluop=11 (never produced) → 010.

## Timing
- Reset: when reset_n=0 at a rising edge, state=FETCH1 after that edge, overriding the current state even mid-instruction. Outputs then show FETCH1 values: memread=1, alusrcb=01, irwrite=0001, pcen=1, alucont=010, all others 0.
- Before the first reset edge, outputs are undefined.
- One state per cycle; no stalls.
- Cycles per instruction, FETCH1 through the final state inclusive:
  - lb: 8
  - sb, R-type, addi: 7
  - beq, j: 6
  - unknown opcode: 5
- op and funct are sampled in DECODE, MEMADR and RTYPEEX. They must be stable from FETCH4 (irwrite[3] load) onward.
- zero is used only in BEQEX, in the same cycle. pcen in BEQEX follows zero with no register delay.

## Structure
- Shared package mips_pkg:
  - State encodings: FETCH1=0 … ADDIWR=14, in the order listed above.
  - Opcode constants: OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI.
  - Funct constants.
  - ALU control constants: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111.
  - aluop constants.
- Sub-module alu_decoder (inputs aluop and funct, output alucont), purely combinational and instantiated once.
- The FSM next-state logic and output decode live in mips_controller.

## Test plan
- Reset mid-instruction: drive reset_n=0 for one edge while in RTYPEEX → state=FETCH1, irwrite=0001, pcen=1, regwrite=0 next cycle.
- R-type `or` (op=000000, funct=100101) → irwrite walks 0001/0010/0100/1000; then DECODE; then RTYPEEX with alucont=001 and alusrca=1; then RTYPEWR with regwrite=1 and regdst=1; back in FETCH1 at cycle 8.
- lb (op=100000) → MEMADR alucont=010; LBRD memread=1 and iord=1; LBWR regwrite=1 and memtoreg=1; 8 cycles total. sb (op=101000) → SBWR memwrite=1; 7 cycles.
- beq with zero=1 in BEQEX → pcen=1, pcsource=01, alucont=110. Same instruction with zero=0 → pcen=0. Both return to FETCH1.
- j (op=000010) → JEX pcen=1, pcsource=10. Unknown op=111111 → FETCH1 right after DECODE with no strobes.
- alu_decoder sweep: aluop=10 with each legal funct gives the listed codes; funct=000000 → 010; aluop=11 → 010.
